// File: rtl/hnf_pkg.sv
// Shared HN-F types: CHI request flit, POCQ entry index and line geometry.
package hnf_pkg;

  localparam int unsigned HNF_ADDR_W      = 44;
  localparam int unsigned HNF_LINE_OFFSET = 6;
  localparam int unsigned POCQ_DEPTH      = 16;
  localparam int unsigned POCQ_ID_W       = $clog2(POCQ_DEPTH);

  typedef logic [POCQ_ID_W-1:0] pocq_id_t;

  typedef struct packed {
    logic [11:0]           txn_id;
    logic [6:0]            opcode;
    logic [HNF_ADDR_W-1:0] addr;
  } reqflit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping; N power of two.
module rr_arbiter #(
  parameter  int unsigned N  = 16,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = ptr + IW'(i);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/pocq_sched.sv
// HN-F point-of-coherence queue: allocates requests, chains same-line hazards
// and issues awake entries round-robin with sleep/wake and retire.
module pocq_sched
  import hnf_pkg::*;
#(
  parameter  int unsigned DEPTH       = POCQ_DEPTH,
  parameter  int unsigned ADDR_W      = HNF_ADDR_W,
  parameter  int unsigned LINE_OFFSET = HNF_LINE_OFFSET,
  localparam int unsigned ID_W        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  input  reqflit_t        alloc_flit,
  output logic            alloc_ready,
  output logic [ID_W-1:0] alloc_id,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [ID_W-1:0] issue_id,
  output reqflit_t        issue_flit,
  input  logic            wake_valid,
  input  logic [ID_W-1:0] wake_id,
  input  logic            retire_valid,
  input  logic [ID_W-1:0] retire_id,
  output logic [ID_W:0]   count,
  output logic            empty,
  output logic            full
);

  logic [DEPTH-1:0] valid, sleep, issued, dep_v, has_succ;
  logic [ID_W-1:0]  dep_id [DEPTH];
  reqflit_t         flits  [DEPTH];
  logic [ID_W-1:0]  rr_ptr;

  logic [DEPTH-1:0] eligible, match_vec;
  logic [ID_W-1:0]  match_id;
  logic             match_v, alloc_fire, issue_fire, retire_ok, wake_ok;

  assign full        = (count == (ID_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = ~full;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign issue_fire  = issue_valid & issue_ready;
  assign retire_ok   = retire_valid & valid[retire_id];
  assign wake_ok     = wake_valid & valid[wake_id] & ~dep_v[wake_id];
  assign eligible    = valid & ~sleep & ~issued;
  assign issue_flit  = flits[issue_id];
  assign match_v     = |match_vec;

  // Lowest free entry from registered valid only.
  always_comb begin
    alloc_id = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_id = ID_W'(i);
    end
  end

  // Same-line open tail search; a tail retiring this cycle cannot take a successor.
  always_comb begin
    match_vec = '0;
    match_id  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_vec[i] = valid[i] & ~has_succ[i] & ~(retire_ok & (retire_id == ID_W'(i))) &
                     (flits[i].addr[ADDR_W-1:LINE_OFFSET] == alloc_flit.addr[ADDR_W-1:LINE_OFFSET]);
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (match_vec[i]) match_id = ID_W'(i);
    end
  end

  rr_arbiter #(.N(DEPTH)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .gnt_valid (issue_valid),
    .gnt_id    (issue_id)
  );

  // Per-entry update; later statements take priority (wake beats issue).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      sleep    <= '0;
      issued   <= '0;
      dep_v    <= '0;
      has_succ <= '0;
      rr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dep_id[i] <= '0;
        flits[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (issue_fire && issue_id == ID_W'(i)) issued[i] <= 1'b1;
        if (wake_ok && wake_id == ID_W'(i)) begin
          issued[i] <= 1'b0;
          sleep[i]  <= 1'b0;
        end
        if (retire_ok && valid[i] && dep_v[i] && dep_id[i] == retire_id) begin
          dep_v[i] <= 1'b0;
          sleep[i] <= 1'b0;
        end
        if (alloc_fire && match_v && match_id == ID_W'(i)) has_succ[i] <= 1'b1;
        if (retire_ok && retire_id == ID_W'(i)) begin
          valid[i]    <= 1'b0;
          issued[i]   <= 1'b0;
          sleep[i]    <= 1'b0;
          has_succ[i] <= 1'b0;
        end
        if (alloc_fire && alloc_id == ID_W'(i)) begin
          valid[i]    <= 1'b1;
          sleep[i]    <= match_v;
          issued[i]   <= 1'b0;
          dep_v[i]    <= match_v;
          dep_id[i]   <= match_id;
          has_succ[i] <= 1'b0;
          flits[i]    <= alloc_flit;
        end
      end
      if (issue_fire) rr_ptr <= issue_id + ID_W'(1);
      case ({alloc_fire, retire_ok})
        2'b10:   count <= count + (ID_W+1)'(1);
        2'b01:   count <= count - (ID_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_alloc_full: assert property (@(posedge clk) disable iff (rst) !(alloc_fire && full));
  a_retire_valid:  assert property (@(posedge clk) disable iff (rst) retire_valid |-> valid[retire_id]);
  a_one_open_line: assert property (@(posedge clk) disable iff (rst) $onehot0(match_vec));
  a_issue_elig:    assert property (@(posedge clk) disable iff (rst) issue_valid |-> eligible[issue_id]);

endmodule

// File: tb/tb_pocq_sched.sv
// Directed bench for pocq_sched: alloc/full, hazard chains, round-robin issue,
// wake-vs-issue priority, retire-while-full and mid-stream reset.
module tb_pocq_sched;
  import hnf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  reqflit_t   alloc_flit;
  logic       alloc_ready;
  logic [3:0] alloc_id;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_id;
  reqflit_t   issue_flit;
  logic       wake_valid;
  logic [3:0] wake_id;
  logic       retire_valid;
  logic [3:0] retire_id;
  logic [4:0] count;
  logic       empty;
  logic       full;

  int n_checks = 0;
  int n_err    = 0;

  pocq_sched dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_flit   (alloc_flit),
    .alloc_ready  (alloc_ready),
    .alloc_id     (alloc_id),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_id     (issue_id),
    .issue_flit   (issue_flit),
    .wake_valid   (wake_valid),
    .wake_id      (wake_id),
    .retire_valid (retire_valid),
    .retire_id    (retire_id),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [43:0] addr);
    alloc_valid       = 1'b1;
    alloc_flit.txn_id = 12'(addr);
    alloc_flit.opcode = 7'h01;
    alloc_flit.addr   = addr;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic wake(input logic [3:0] id);
    wake_valid = 1'b1;
    wake_id    = id;
    step();
    wake_valid = 1'b0;
  endtask

  task automatic retire(input logic [3:0] id);
    retire_valid = 1'b1;
    retire_id    = id;
    step();
    retire_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_flit = '0; issue_ready = 1'b0;
    wake_valid = 1'b0; wake_id = '0; retire_valid = 1'b0; retire_id = '0;
    step();
    do_reset();

    // Reset state
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_id",    64'(alloc_id),    64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_id",    64'(issue_id),    64'd0);
    chk("rst_count",       64'(count),       64'd0);
    chk("rst_empty",       64'(empty),       64'd1);
    chk("rst_full",        64'(full),        64'd0);

    // Fill with 16 distinct lines
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_alloc_id%0d", i), 64'(alloc_id), 64'(i));
      alloc(44'(i) * 44'h40);
    end
    chk("fill_full",        64'(full),        64'd1);
    chk("fill_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("fill_count",       64'(count),       64'd16);
    chk("fill_empty",       64'(empty),       64'd0);
    chk("fill_issue_id",    64'(issue_id),    64'd0);

    // Retire 3 while full with a blocked alloc in the same cycle
    retire_valid = 1'b1; retire_id = 4'd3;
    alloc_valid = 1'b1; alloc_flit.addr = 44'h100000;
    step();
    retire_valid = 1'b0; alloc_valid = 1'b0;
    chk("rf_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rf_alloc_id",    64'(alloc_id),    64'd3);
    chk("rf_count",       64'(count),       64'd15);
    chk("rf_full",        64'(full),        64'd0);

    // Same-line chain A -> B -> C
    do_reset();
    alloc(44'h1000);
    alloc(44'h1020);
    alloc(44'h1008);
    chk("chain_issue_valid0", 64'(issue_valid), 64'd1);
    chk("chain_issue_id0",    64'(issue_id),    64'd0);
    chk("chain_flit0",        64'(issue_flit.addr), 64'h1000);
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    chk("chain_bc_sleep", 64'(issue_valid), 64'd0);
    wake(4'd1);
    chk("chain_wake_dep_ignored", 64'(issue_valid), 64'd0);
    retire(4'd0);
    chk("chain_b_awake",  64'(issue_valid), 64'd1);
    chk("chain_b_id",     64'(issue_id),    64'd1);
    chk("chain_b_flit",   64'(issue_flit.addr), 64'h1020);
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    chk("chain_c_still_sleep", 64'(issue_valid), 64'd0);
    retire(4'd1);
    chk("chain_c_awake", 64'(issue_valid), 64'd1);
    chk("chain_c_id",    64'(issue_id),    64'd2);
    chk("chain_count",   64'(count),       64'd1);

    // Round-robin order and wrap
    do_reset();
    alloc(44'h0);
    alloc(44'h40);
    alloc(44'h80);
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rr_valid%0d", k), 64'(issue_valid), 64'd1);
      chk($sformatf("rr_id%0d", k),    64'(issue_id),    64'(k));
      step();
    end
    issue_ready = 1'b0;
    chk("rr_drained", 64'(issue_valid), 64'd0);
    wake(4'd0);
    chk("rr_wrap_valid", 64'(issue_valid), 64'd1);
    chk("rr_wrap_id",    64'(issue_id),    64'd0);

    // Wake beats a same-cycle issue handshake on the same entry
    do_reset();
    for (int i = 0; i < 6; i++) alloc(44'h10000 + 44'(i) * 44'h40);
    issue_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wi_id%0d", k), 64'(issue_id), 64'(k));
      step();
    end
    issue_ready = 1'b0;
    chk("wi_drained", 64'(issue_valid), 64'd0);
    wake(4'd5);
    chk("wi_woken_valid", 64'(issue_valid), 64'd1);
    chk("wi_woken_id",    64'(issue_id),    64'd5);
    issue_ready = 1'b1; wake_valid = 1'b1; wake_id = 4'd5;
    step();
    wake_valid = 1'b0;
    chk("wi_stays_valid", 64'(issue_valid), 64'd1);
    chk("wi_stays_id",    64'(issue_id),    64'd5);
    step();
    issue_ready = 1'b0;
    chk("wi_reissued", 64'(issue_valid), 64'd0);

    // Mid-stream reset with 7 entries, 2 sleeping
    do_reset();
    alloc(44'h2000);
    alloc(44'h2010);
    alloc(44'h2020);
    alloc(44'h3000);
    alloc(44'h3040);
    alloc(44'h3080);
    alloc(44'h30c0);
    chk("mr_count_before", 64'(count), 64'd7);
    chk("mr_alloc_id_before", 64'(alloc_id), 64'd7);
    rst = 1'b1;
    step();
    chk("mr_count",       64'(count),       64'd0);
    chk("mr_issue_valid", 64'(issue_valid), 64'd0);
    chk("mr_alloc_id",    64'(alloc_id),    64'd0);
    chk("mr_empty",       64'(empty),       64'd1);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pocq_sched.md
Name: pocq_sched

Overview:
- Point-of-coherence queue for the HN-F, successor to the single-entry fill buffer.
- Holds up to DEPTH CHI requests and allocates the lowest free entry with a ready/valid handshake.
- Orders same-cache-line requests through a per-entry dependency chain and issues awake entries to the HN-F pipeline round-robin.
- Supports sleep/wake on pipeline retry and frees entries on retire.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2.
- ADDR_W, 44, width of reqflit_t addr field used for hazard compare.
- LINE_OFFSET, 6, low address bits ignored for the same-line compare (64B line).
- ID_W, $clog2(DEPTH), localparam, entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  request to enqueue
- alloc_flit  in  reqflit_t  request flit
- alloc_ready  out  1  not full
- alloc_id  out  ID_W  entry index that will be used; valid when alloc_ready
- issue_valid  out  1  an eligible entry exists
- issue_ready  in  1  pipeline accepts
- issue_id  out  ID_W  selected entry
- issue_flit  out  reqflit_t  flit of selected entry
- wake_valid  in  1  retry: make entry eligible again
- wake_id  in  ID_W  entry to wake
- retire_valid  in  1  transaction complete, free entry
- retire_id  in  ID_W  entry to free
- count  out  ID_W+1  occupied entries
- empty  out  1  count==0
- full  out  1  count==DEPTH

Behaviour:
- Per-entry state: valid, sleep, issued, dep_v, dep_id, has_succ, flit.
- Reset clears all state bits (flits to 0). Outputs after reset: alloc_ready=1, alloc_id=0, issue_valid=0, issue_id=0, count=0, empty=1, full=0. The round-robin pointer resets to 0.
- A reset in mid-operation drops every entry with no completion.
- Alloc:
  - Fires when alloc_valid & alloc_ready. The entry is written at the next clock edge.
  - alloc_id is the lowest index with valid=0, computed from registered valid only. An entry retired in the same cycle is not reusable until the next cycle, and full does not drop until then.
  - Hazard: compare addr[ADDR_W-1:LINE_OFFSET] against valid entries with has_succ=0, excluding an entry retired in the same cycle. At most one entry matches.
  - On a match: the new entry gets dep_v=1, dep_id=match, sleep=1, and the match sets has_succ=1.
  - With no match: dep_v=0 and sleep=0.
- Issue:
  - Eligible means valid & ~sleep & ~issued.
  - The selection is combinational from registered state: the first eligible index at or after the rr pointer, wrapping.
  - On issue_valid & issue_ready: set issued=1 and move the pointer to issue_id+1 mod DEPTH. Without a handshake the pointer holds.
  - issue_id and issue_flit are stable while issue_valid=1 & issue_ready=0, unless a lower-priority state change makes a new entry win. The arbiter stays work-conserving with no lock requirement.
  - A newly allocated entry is eligible at the earliest one cycle after alloc.
- Wake:
  - On a valid entry with dep_v=0: clear issued and sleep.
  - Ignored on an invalid entry or one with dep_v=1.
  - A wake and an issue handshake on the same id in the same cycle: wake wins, so the entry stays eligible.
- Retire:
  - Clears valid, issued, sleep and has_succ for retire_id.
  - Every valid entry with dep_v=1 & dep_id==retire_id (at most one) clears dep_v and sleep the next cycle.
  - Retiring a never-issued entry is legal (cancel).
  - Retiring an invalid entry is ignored and flagged by an assertion.
  - Retire and alloc in the same cycle are independent, apart from the hazard exclusion above.
- count: +1 on alloc, -1 on a valid retire, unchanged when both happen.
- Assertions:
  - no alloc when full;
  - at most one has_succ=0 entry per line;
  - issue_id is eligible whenever issue_valid=1.

Decomposition:
- hnf_pkg holds reqflit_t (with addr field), pocq_id_t, and the LINE_OFFSET default.
- Sub-module: rr_arbiter #(N) with inputs req[N] and ptr, outputs gnt_valid and gnt_id. It is reused later by the HN-F retry queue.
- The lowest-free-index find-first stays inline.

Test Plan:
- Reset then 16 allocs with distinct lines:
  - alloc_id takes 0..15 in order;
  - full=1 after the 16th and alloc_ready=0;
  - count=16.
- Alloc A(addr 0x1000) then B(0x1020, same line) then C(0x1008):
  - B gets dep on 0, C gets dep on 1, and both sleep;
  - retire 0 wakes B only, and B issues the next cycle;
  - retire 1 wakes C.
- Entries 0,1,2 awake, issue_ready=1 always: issue order is 0,1,2. Re-wake 0 after the pointer reaches 3: 0 issues next (wrap).
- Issue 5 then wake_id=5 in the same cycle as another issue handshake on 5: entry 5 stays eligible and reissues.
- Full queue with retire_id=3 and alloc_valid in the same cycle:
  - no alloc;
  - the next cycle alloc_ready=1, alloc_id=3, count=15.
- Assert rst mid-stream with 7 entries, 2 sleeping: the next cycle count=0, issue_valid=0 and alloc_id=0.
